// File: rtl/mem_txn_ctrl_pkg.sv
// ServiceProtocol: shared types for the memory transaction controller.
//   txn_state_e : controller FSM state encoding
//   rb_cause_e  : why a transaction was rolled back
//   sat_inc8    : saturating 8-bit increment used for the error counter
package ServiceProtocol;

  localparam int WORD_CNT_W = 16;
  localparam int ERR_CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPEN,
    ST_ACTIVE,
    ST_COMMIT,
    ST_ROLLBACK
  } txn_state_e;

  typedef enum logic [2:0] {
    RB_NONE,
    RB_FRAME_ERR,
    RB_FRAME_START,
    RB_OVERFLOW,
    RB_TIMEOUT
  } rb_cause_e;

  function automatic logic [ERR_CNT_W-1:0] sat_inc8(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_txn_ctrl_timeout.sv
// txn_timeout_counter: counts ACTIVE cycles with no word pushed.
//   clk, rst   : clock, synchronous active-high reset
//   clear_i    : restart the idle count (entry to ACTIVE or a word pushed)
//   run_i      : controller is in ACTIVE
//   expired_o  : this cycle is the TIMEOUT_CYCLES-th idle cycle
module txn_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                         cnt_d = '0;
    else if (run_i && (cnt_q != LAST))   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // cnt_q holds the number of idle cycles already elapsed, so the cycle
  // that sees LAST is the final permitted idle cycle.
  assign expired_o = run_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_txn_ctrl.sv
// mem_txn_ctrl: wraps one SPI TCC_SEND_DATA frame in a ring-buffer
// transaction (open -> push words -> commit, or rollback on any fault).
// Optional feature macro: MEM_TXN_CTRL_TIMEOUT_EN (idle timeout in ACTIVE).
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   cmd_send                          : address-matched send command decoded
//   frame_start/frame_end/frame_err   : SPI frame event pulses
//   word_pushed                       : a word entered the ring buffer
//   mem_free[15:0]                    : free words in the ring buffer
//   rb_open/rb_commit/rb_rollback     : registered one-cycle buffer controls
//   push_en                           : SPI-to-memory path enable (ACTIVE)
//   busy                              : FSM not idle
//   err_count[7:0]                    : saturating rollback count
module mem_txn_ctrl
  import ServiceProtocol::*;
#(
  parameter int MAX_WORDS      = 256,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_send,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic        frame_err,
  input  logic        word_pushed,
  input  logic [15:0] mem_free,
  output logic        rb_open,
  output logic        rb_commit,
  output logic        rb_rollback,
  output logic        push_en,
  output logic        busy,
  output logic [7:0]  err_count
);

  txn_state_e             state_q, state_d;
  rb_cause_e              cause;
  logic [WORD_CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic                   rb_open_q, rb_commit_q, rb_rollback_q, push_en_q, busy_q;
  logic                   overflow, timeout_hit;

`ifdef MEM_TXN_CTRL_TIMEOUT_EN
  txn_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear_i   ((state_q == ST_OPEN) || word_pushed),
    .run_i     (state_q == ST_ACTIVE),
    .expired_o (timeout_hit)
  );
`else
  // Timeout disabled; the parameter stays on the interface so both builds
  // share one instantiation.
  localparam bit TO_CFG = (TIMEOUT_CYCLES > 0);
  assign timeout_hit = TO_CFG & 1'b0;
`endif

  // A push that finds the transaction full or the buffer full is lost data.
  assign overflow = word_pushed &&
                    ((word_cnt_q == WORD_CNT_W'(MAX_WORDS)) || (mem_free == '0));

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    cause      = RB_NONE;
    unique case (state_q)
      ST_IDLE:   if (frame_start && cmd_send) state_d = ST_OPEN;
      ST_OPEN: begin
        word_cnt_d = '0;
        state_d    = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (word_pushed) word_cnt_d = word_cnt_q + 1'b1;
        // Any fault beats a clean end; a new frame_start aborts and is dropped.
        if (frame_err)        cause = RB_FRAME_ERR;
        else if (frame_start) cause = RB_FRAME_START;
        else if (overflow)    cause = RB_OVERFLOW;
        else if (timeout_hit) cause = RB_TIMEOUT;
        if (cause != RB_NONE) state_d = ST_ROLLBACK;
        else if (frame_end)   state_d = ST_COMMIT;
      end
      ST_COMMIT:   state_d = ST_IDLE;
      ST_ROLLBACK: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    err_cnt_d = (cause != RB_NONE) ? sat_inc8(err_cnt_q) : err_cnt_q;
  end

  // Outputs are flopped from the next state so each pulse is glitch-free and
  // coincides with the state it names.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      word_cnt_q    <= '0;
      err_cnt_q     <= '0;
      rb_open_q     <= 1'b0;
      rb_commit_q   <= 1'b0;
      rb_rollback_q <= 1'b0;
      push_en_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      err_cnt_q     <= err_cnt_d;
      rb_open_q     <= (state_d == ST_OPEN);
      rb_commit_q   <= (state_d == ST_COMMIT);
      rb_rollback_q <= (state_d == ST_ROLLBACK);
      push_en_q     <= (state_d == ST_ACTIVE);
      busy_q        <= (state_d != ST_IDLE);
    end
  end

  assign rb_open     = rb_open_q;
  assign rb_commit   = rb_commit_q;
  assign rb_rollback = rb_rollback_q;
  assign push_en     = push_en_q;
  assign busy        = busy_q;
  assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_mem_txn_ctrl.sv
// Bench for mem_txn_ctrl: directed scenarios plus randomized transactions
// scored at transaction level (outcome, pulse counts, error count).
module tb_mem_txn_ctrl;

  localparam int MAXW = 12;
  localparam int TO   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_send = 1'b0, frame_start = 1'b0, frame_end = 1'b0;
  logic        frame_err = 1'b0, word_pushed = 1'b0;
  logic [15:0] mem_free = 16'd100;
  logic        rb_open, rb_commit, rb_rollback, push_en, busy;
  logic [7:0]  err_count;

  int ncmp = 0, nerr = 0;
  int n_open = 0, n_commit = 0, n_rb = 0;
  int exp_err = 0;
  bit mon_en = 1'b0;

  mem_txn_ctrl #(.MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cmd_send(cmd_send), .frame_start(frame_start),
    .frame_end(frame_end), .frame_err(frame_err), .word_pushed(word_pushed),
    .mem_free(mem_free), .rb_open(rb_open), .rb_commit(rb_commit),
    .rb_rollback(rb_rollback), .push_en(push_en), .busy(busy),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_add(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Pulse counting and per-cycle invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [1:0] s;
      s = {1'b0, rb_open} + {1'b0, rb_commit} + {1'b0, rb_rollback};
      chk("pulse_exclusive", {31'b0, s <= 2'd1}, 32'd1);
      chk("push_en_implies_busy", {31'b0, push_en & ~busy}, 32'd0);
      n_open   += int'(rb_open);
      n_commit += int'(rb_commit);
      n_rb     += int'(rb_rollback);
    end
  end

  task automatic open_txn();
    cmd_send = 1'b1; frame_start = 1'b1;
    step();
    cmd_send = 1'b0; frame_start = 1'b0;
    step();  // now in ACTIVE
  endtask

  // One random transaction; expected outcome derived from the rules alone.
  task automatic run_txn(input int idx);
    int n, kind, zero_at, o0, c0, r0;
    bit ovf, rollback;
    n       = $urandom_range(0, 15);
    kind    = $urandom_range(0, 3);  // 0 end, 1 err, 2 end+err, 3 new start
    zero_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 99;
    ovf      = (n > MAXW) || (zero_at < n && zero_at <= MAXW);
    rollback = ovf || (kind != 0);
    o0 = n_open; c0 = n_commit; r0 = n_rb;
    open_txn();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) step();
      mem_free    = (i == zero_at) ? 16'd0 : 16'($urandom_range(1, 65535));
      word_pushed = 1'b1;
      step();
      word_pushed = 1'b0;
      mem_free    = 16'd100;
    end
    case (kind)
      0: frame_end = 1'b1;
      1: frame_err = 1'b1;
      2: begin frame_end = 1'b1; frame_err = 1'b1; end
      default: frame_start = 1'b1;  // cmd_send low: must not reopen in IDLE
    endcase
    step();
    frame_end = 1'b0; frame_err = 1'b0; frame_start = 1'b0;
    repeat (3) step();
    if (rollback) exp_err = sat_add(exp_err);
    chk($sformatf("rnd%0d_open", idx), n_open - o0, 1);
    chk($sformatf("rnd%0d_commit", idx), n_commit - c0, rollback ? 0 : 1);
    chk($sformatf("rnd%0d_rollback", idx), n_rb - r0, rollback ? 1 : 0);
    chk($sformatf("rnd%0d_err_count", idx), {24'b0, err_count}, exp_err);
    chk($sformatf("rnd%0d_idle", idx), {30'b0, busy, push_en}, 0);
  endtask

  initial begin
    int r0, o0, c0;

    // Reset state
    step(); step();
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_pulses", {29'b0, rb_open, rb_commit, rb_rollback}, 0);
    chk("rst_push_en", {31'b0, push_en}, 0);
    chk("rst_err_count", {24'b0, err_count}, 0);
    rst = 1'b0;
    step();
    mon_en = 1'b1;

    // Ignored frame_start without cmd_send
    frame_start = 1'b1; step(); frame_start = 1'b0;
    chk("nocmd_ignored", {31'b0, busy}, 0);

    // Clean 10-word commit with exact pulse timing
    cmd_send = 1'b1; frame_start = 1'b1;
    step();
    cmd_send = 1'b0; frame_start = 1'b0;
    chk("open_pulse", {31'b0, rb_open}, 1);
    chk("open_no_push", {31'b0, push_en}, 0);
    step();
    chk("open_one_cycle", {31'b0, rb_open}, 0);
    chk("active_push_en", {31'b0, push_en}, 1);
    word_pushed = 1'b1;
    repeat (10) step();
    word_pushed = 1'b0;
    chk("active_after_10", {31'b0, push_en}, 1);
    frame_end = 1'b1; step(); frame_end = 1'b0;
    chk("commit_pulse", {31'b0, rb_commit}, 1);
    chk("commit_no_push", {31'b0, push_en}, 0);
    step();
    chk("commit_one_cycle", {31'b0, rb_commit}, 0);
    chk("commit_idle", {31'b0, busy}, 0);
    chk("commit_err_count", {24'b0, err_count}, 0);

    // Idle timeout (macro) or persistence (default)
    r0 = n_rb;
    open_txn();
    repeat (40) step();
`ifdef MEM_TXN_CTRL_TIMEOUT_EN
    exp_err = sat_add(exp_err);
    chk("timeout_rollback", n_rb - r0, 1);
    chk("timeout_idle", {31'b0, busy}, 0);
`else
    chk("no_timeout_active", {31'b0, push_en}, 1);
    chk("no_timeout_no_rb", n_rb - r0, 0);
    frame_end = 1'b1; step(); frame_end = 1'b0;
    chk("no_timeout_commit", {31'b0, rb_commit}, 1);
    step();
`endif

    // Word limit: MAXW pushes fine, the next one overflows
    open_txn();
    word_pushed = 1'b1;
    repeat (MAXW) step();
    chk("at_max_active", {31'b0, push_en}, 1);
    step();
    word_pushed = 1'b0;
    exp_err = sat_add(exp_err);
    chk("ovf_rollback", {31'b0, rb_rollback}, 1);
    chk("ovf_push_en", {31'b0, push_en}, 0);
    chk("ovf_err_count", {24'b0, err_count}, exp_err);
    step();

    // frame_end and frame_err together -> rollback only
    open_txn();
    frame_end = 1'b1; frame_err = 1'b1; step(); frame_end = 1'b0; frame_err = 1'b0;
    exp_err = sat_add(exp_err);
    chk("both_rollback", {31'b0, rb_rollback}, 1);
    chk("both_no_commit", {31'b0, rb_commit}, 0);
    step();
    chk("both_no_late_commit", {31'b0, rb_commit}, 0);

    // Push into a full buffer
    open_txn();
    mem_free = 16'd0; word_pushed = 1'b1; step(); word_pushed = 1'b0; mem_free = 16'd100;
    exp_err = sat_add(exp_err);
    chk("memfull_rollback", {31'b0, rb_rollback}, 1);
    step();

    // frame_start during ACTIVE aborts and is not reopened
    open_txn();
    o0 = n_open;
    cmd_send = 1'b1; frame_start = 1'b1; step(); cmd_send = 1'b0; frame_start = 1'b0;
    exp_err = sat_add(exp_err);
    chk("restart_rollback", {31'b0, rb_rollback}, 1);
    repeat (3) step();
    chk("restart_no_reopen", n_open - o0, 0);
    chk("restart_idle", {31'b0, busy}, 0);

    // Randomized transactions
    for (int i = 0; i < 40; i++) run_txn(i);

    // Reset mid-transaction, coincident with frame_end
    r0 = n_rb; c0 = n_commit;
    open_txn();
    word_pushed = 1'b1; repeat (3) step(); word_pushed = 1'b0;
    rst = 1'b1; frame_end = 1'b1; step(); rst = 1'b0; frame_end = 1'b0;
    exp_err = 0;
    chk("rst_mid_outputs", {26'b0, rb_open, rb_commit, rb_rollback, push_en, busy, 1'b0}, 0);
    chk("rst_mid_err_count", {24'b0, err_count}, 0);
    repeat (3) step();
    chk("rst_mid_no_rollback", n_rb - r0, 0);
    chk("rst_mid_no_commit", n_commit - c0, 0);

    // Saturation after 300 rollbacks
    for (int i = 0; i < 300; i++) begin
      open_txn();
      frame_err = 1'b1; step(); frame_err = 1'b0;
      exp_err = sat_add(exp_err);
      step();
      if (i == 254) chk("err_count_at_255", {24'b0, err_count}, exp_err);
    end
    chk("err_count_saturated", {24'b0, err_count}, exp_err);
    chk("err_count_limit", exp_err, 255);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
